z80_io_mailbox: RTL and testbench

Z80 bus-side I/O responder that answers the CPU's IORQ/RD/WR cycles and IM2 interrupt-acknowledge cycles. It sits on the pin-compatible Z80 bus beside the T80 core and bridges CPU port accesses to on-chip valid/ready streams. CPU writes go into a TX FIFO; the local side supplies single bytes through an RX holding register for CPU reads. All bus pins are sampled on a fast local clock, at least 4× the Z80 `CLK_n` frequency.

---
 rtl/z80_io_mailbox.sv | 175 +++++++++++++++++
 tb/tb_z80_io_mailbox.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_mailbox.sv
// Z80 IORQ/RD/WR responder bridging CPU port accesses to TX FIFO / RX holding byte streams.
// Optional interrupt support (ie, int_n, IM2 vector) is built when Z80_IO_MAILBOX_IRQ_EN is defined.
module z80_io_mailbox #(
    parameter logic [7:0] BASE_ADDR  = 8'h40,
    parameter int         TX_DEPTH   = 4,
    parameter logic [7:0] IRQ_VECTOR = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    output logic       int_n,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);
    localparam int AW = $clog2(TX_DEPTH);

    logic [1:0] iorq_sync_q, rd_sync_q, wr_sync_q, m1_sync_q;
    logic [1:0] settle_q;
    logic       armed_q;
    logic       iorq_s, rd_s, wr_s, m1_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iorq_sync_q <= 2'b11;
            rd_sync_q   <= 2'b11;
            wr_sync_q   <= 2'b11;
            m1_sync_q   <= 2'b11;
            settle_q    <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            iorq_sync_q <= {iorq_sync_q[0], iorq_n};
            rd_sync_q   <= {rd_sync_q[0], rd_n};
            wr_sync_q   <= {wr_sync_q[0], wr_n};
            m1_sync_q   <= {m1_sync_q[0], m1_n};
            settle_q    <= {settle_q[0], 1'b1};
            // Only arm once the synchronizers hold real pin state and IORQ is idle,
            // so a cycle straddling reset release is ignored entirely.
            if (settle_q[1] && iorq_s)
                armed_q <= 1'b1;
        end
    end

    assign iorq_s = iorq_sync_q[1];
    assign rd_s   = rd_sync_q[1];
    assign wr_s   = wr_sync_q[1];
    assign m1_s   = m1_sync_q[1];

    logic hit, io_rd, io_wr;
    logic io_rd_q, io_wr_q, rd_port_q;
    logic wr_rise, rd_fall, data_wr, stat_wr, rx_pop;

    assign hit     = (a[7:1] == BASE_ADDR[7:1]);
    assign io_rd   = armed_q & ~iorq_s & ~rd_s & m1_s & hit;
    assign io_wr   = armed_q & ~iorq_s & ~wr_s & m1_s & hit;
    assign wr_rise = io_wr & ~io_wr_q;
    assign rd_fall = io_rd_q & ~io_rd;
    assign data_wr = wr_rise & ~a[0];
    assign stat_wr = wr_rise & a[0];

    // TX FIFO: extra pointer bit distinguishes full from empty
    logic [7:0]  tx_mem [TX_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        tx_full, tx_empty, tx_push, tx_pop;

    assign tx_empty = (wr_ptr_q == rd_ptr_q);
    assign tx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[rd_ptr_q[AW-1:0]];
    assign tx_push  = data_wr & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[wr_ptr_q[AW-1:0]] <= d_in;
    end

    logic       ovf_q, rx_full_q;
    logic [7:0] rx_hold_q;
    logic       ie_bit;
    logic [7:0] status;
    logic [7:0] d_out_d, d_out_q;
    logic       d_oe_d, d_oe_q;

    assign rx_ready = ~rx_full_q;
    assign rx_pop   = rd_fall & ~rd_port_q & rx_full_q;
    assign status   = {ovf_q, 3'b000, ie_bit, tx_empty, tx_full, rx_full_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_rd_q   <= 1'b0;
            io_wr_q   <= 1'b0;
            rd_port_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            rx_full_q <= 1'b0;
            rx_hold_q <= 8'h00;
            d_out_q   <= 8'h00;
            d_oe_q    <= 1'b0;
        end else begin
            io_rd_q <= io_rd;
            io_wr_q <= io_wr;
            if (io_rd)
                rd_port_q <= a[0];
            if (tx_push)
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (tx_pop)
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            if (stat_wr && d_in[7])
                ovf_q <= 1'b0;
            else if (data_wr && tx_full)
                ovf_q <= 1'b1;
            if (rx_pop) begin
                rx_full_q <= 1'b0;
            end else if (rx_valid && !rx_full_q) begin
                rx_full_q <= 1'b1;
                rx_hold_q <= rx_data;
            end
            d_out_q <= d_out_d;
            d_oe_q  <= d_oe_d;
        end
    end

`ifdef Z80_IO_MAILBOX_IRQ_EN
    logic ie_q, int_n_q, inta;

    assign inta   = armed_q & ~iorq_s & ~m1_s;
    assign ie_bit = ie_q;
    assign int_n  = int_n_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q    <= 1'b0;
            int_n_q <= 1'b1;
        end else begin
            if (stat_wr)
                ie_q <= d_in[3];
            int_n_q <= ~(ie_q & rx_full_q);
        end
    end

    always_comb begin
        d_oe_d  = io_rd | inta;
        d_out_d = 8'h00;
        if (inta)
            d_out_d = IRQ_VECTOR;
        else if (io_rd)
            d_out_d = a[0] ? status : (rx_full_q ? rx_hold_q : 8'hFF);
    end
`else
    assign ie_bit = 1'b0;
    assign int_n  = 1'b1;

    always_comb begin
        d_oe_d  = io_rd;
        d_out_d = 8'h00;
        if (io_rd)
            d_out_d = a[0] ? status : (rx_full_q ? rx_hold_q : 8'hFF);
    end
`endif

    assign d_out = d_out_q;
    assign d_oe  = d_oe_q;
endmodule

// File: tb/tb_z80_io_mailbox.sv
// Directed bench for z80_io_mailbox: expected bus-read bytes and TX bytes are queued by the
// stimulus and consumed by a monitor that watches d_oe fall and TX handshakes.
module tb_z80_io_mailbox;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, d_in, d_out, tx_data, rx_data;
    logic       d_oe, iorq_n, rd_n, wr_n, m1_n, int_n;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] bus_last = 8'h00;
    logic       d_oe_prev = 1'b0;

    always #5 clk = ~clk;

    z80_io_mailbox #(.BASE_ADDR(8'h40), .TX_DEPTH(4), .IRQ_VECTOR(8'hF0)) dut (
        .clk(clk), .rst(rst), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .int_n(int_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_tx.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL tx_unexpected: got %02h expected none", tx_data);
            end else begin
                check("tx_data", tx_data, exp_tx.pop_front());
            end
        end
        if (d_oe === 1'b1) begin
            bus_last = d_out;
        end else if (d_oe_prev) begin
            if (exp_bus.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL bus_unexpected: got %02h expected no drive", bus_last);
            end else begin
                check("bus_read", bus_last, exp_bus.pop_front());
            end
        end
        d_oe_prev = (d_oe === 1'b1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_out(input logic [7:0] port, input logic [7:0] val);
        a = port; d_in = val;
        wait_clk(2);
        iorq_n = 1'b0; wr_n = 1'b0;
        wait_clk(8);
        iorq_n = 1'b1; wr_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic io_in(input logic [7:0] port);
        a = port;
        wait_clk(2);
        iorq_n = 1'b0; rd_n = 1'b0;
        wait_clk(8);
        iorq_n = 1'b1; rd_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic inta_cycle();
        wait_clk(2);
        m1_n = 1'b0; iorq_n = 1'b0;
        wait_clk(8);
        m1_n = 1'b1; iorq_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic rx_supply(input logic [7:0] val);
        rx_data = val; rx_valid = 1'b1;
        wait_clk(1);
        rx_valid = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        logic [7:0] ovf_bytes [5];
        ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rst = 1'b1; a = 8'h00; d_in = 8'h00;
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        wait_clk(3);
        check("rst_d_oe", {7'd0, d_oe}, 8'h00);
        check("rst_d_out", d_out, 8'h00);
        check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        check("rst_int_n", {7'd0, int_n}, 8'h01);
        check("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
        rst = 1'b0;
        wait_clk(4);
        exp_bus.push_back(8'h04);
        io_in(8'h41);

        // Push and drain
        tx_ready = 1'b1;
        exp_tx.push_back(8'hA5);
        io_out(8'h40, 8'hA5);
        exp_tx.push_back(8'h3C);
        io_out(8'h40, 8'h3C);
        check("drain_tx_valid", {7'd0, tx_valid}, 8'h00);
        exp_bus.push_back(8'h04);
        io_in(8'h41);

        // Overflow: fifth byte dropped
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) io_out(8'h40, ovf_bytes[i]);
        exp_bus.push_back(8'h82);
        io_in(8'h41);
        io_out(8'h41, 8'h80);
        exp_bus.push_back(8'h02);
        io_in(8'h41);
        for (int i = 0; i < 4; i++) exp_tx.push_back(ovf_bytes[i]);
        tx_ready = 1'b1;
        wait_clk(8);
        check("ovf_drained", {7'd0, tx_valid}, 8'h00);

        // RX read, then empty read returns FF
        rx_supply(8'h5A);
        check("rx_ready_full", {7'd0, rx_ready}, 8'h00);
        exp_bus.push_back(8'h5A);
        io_in(8'h40);
        check("rx_ready_free", {7'd0, rx_ready}, 8'h01);
        exp_bus.push_back(8'hFF);
        io_in(8'h40);

        // Interrupt
        io_out(8'h41, 8'h08);
        rx_supply(8'h77);
`ifdef Z80_IO_MAILBOX_IRQ_EN
        check("int_n_asserted", {7'd0, int_n}, 8'h00);
        exp_bus.push_back(8'hF0);
        inta_cycle();
        exp_bus.push_back(8'h0D);
        io_in(8'h41);
`else
        check("int_n_tied", {7'd0, int_n}, 8'h01);
        inta_cycle();
        exp_bus.push_back(8'h05);
        io_in(8'h41);
`endif
        exp_bus.push_back(8'h77);
        io_in(8'h40);
        check("int_n_released", {7'd0, int_n}, 8'h01);

        // Non-decoded port 42
        io_out(8'h41, 8'h00);
        tx_ready = 1'b0;
        rx_supply(8'h99);
        io_in(8'h42);
        io_out(8'h42, 8'hEE);
        check("nodec_tx_valid", {7'd0, tx_valid}, 8'h00);
        check("nodec_rx_ready", {7'd0, rx_ready}, 8'h00);
        exp_bus.push_back(8'h99);
        io_in(8'h40);

        // Reset in the middle of a DATA read
        rx_supply(8'h42);
        a = 8'h40;
        wait_clk(2);
        iorq_n = 1'b0; rd_n = 1'b0;
        exp_bus.push_back(8'h42);
        wait_clk(6);
        rst = 1'b1;
        #1;
        check("midrst_d_oe", {7'd0, d_oe}, 8'h00);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        rx_supply(8'h6B);
        iorq_n = 1'b1; rd_n = 1'b1;
        wait_clk(8);
        check("midrst_no_pop", {7'd0, rx_ready}, 8'h00);
        check("midrst_no_push", {7'd0, tx_valid}, 8'h00);
        exp_bus.push_back(8'h6B);
        io_in(8'h40);
        exp_bus.push_back(8'h04);
        io_in(8'h41);

        wait_clk(4);
        while (exp_bus.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL bus_missing: got no read expected %02h", exp_bus.pop_front());
        end
        while (exp_tx.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL tx_missing: got no byte expected %02h", exp_tx.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
